// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock derived from 100 MHz.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_COUNT_W   = 10;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  // Sync window is the half-open range [start, end).
  function automatic int sync_start(input int visible, input int front);
    return visible + front;
  endfunction

  function automatic int sync_end(input int visible, input int front, input int sync);
    return visible + front + sync;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int DEF_H_SYNC_START = sync_start(DEF_H_VISIBLE, DEF_H_FRONT);
  localparam int DEF_H_SYNC_END   = sync_end(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = sync_start(DEF_V_VISIBLE, DEF_V_FRONT);
  localparam int DEF_V_SYNC_END   = sync_end(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One wrapping position counter (used for both columns and lines) with
// combinational sync-window and visible-area decode.
module vga_axis_counter #(
  parameter int COUNT_W    = 10,
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output logic               inSync,
  output logic               inVisible
);

  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] VIS_END = COUNT_W'(VISIBLE);
  localparam logic [COUNT_W-1:0] SS      = COUNT_W'(SYNC_START);
  localparam logic [COUNT_W-1:0] SE      = COUNT_W'(SYNC_END);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + COUNT_W'(1);
    end
  end

  assign wrap      = step && (count == LAST);
  assign inSync    = (count >= SS) && (count < SE);
  assign inVisible = (count < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate prescaler, column/line counters, sync and
// visible-area decode, line/frame strobes and an optional output delay line.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int OUT_DELAY  = 0
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               enable,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               pixelTick,
  output logic               lineStart,
  output logic               frameStart
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if ((2 ** COUNT_W) < MAX_TOTAL) begin : g_bad_count_w
    $error("vga_timing_gen: COUNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (OUT_DELAY < 0 || OUT_DELAY > 4) begin : g_bad_out_delay
    $error("vga_timing_gen: OUT_DELAY must be 0..4");
  end

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  logic             run;
  logic             h_wrap, h_in_sync, h_in_visible;
  logic             v_wrap, v_in_sync, v_in_visible;
  logic [2:0]       decoded;
  logic [2:0]       idle;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      prescaler <= '0;
      run       <= 1'b0;
    end else if (enable) begin
      run       <= 1'b1;
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
    end
  end

  // Gated by clear so that CLK_DIV=1 cannot tick while reset is held.
  assign pixelTick = clear && enable && (prescaler == PRE_LAST);

  vga_axis_counter #(
    .COUNT_W(COUNT_W), .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
    .SYNC_START(sync_start(H_VISIBLE, H_FRONT)),
    .SYNC_END(sync_end(H_VISIBLE, H_FRONT, H_SYNC))
  ) u_h_axis (
    .clock(clock), .clear(clear), .step(pixelTick),
    .count(hCount), .wrap(h_wrap), .inSync(h_in_sync), .inVisible(h_in_visible)
  );

  vga_axis_counter #(
    .COUNT_W(COUNT_W), .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
    .SYNC_START(sync_start(V_VISIBLE, V_FRONT)),
    .SYNC_END(sync_end(V_VISIBLE, V_FRONT, V_SYNC))
  ) u_v_axis (
    .clock(clock), .clear(clear), .step(h_wrap),
    .count(vCount), .wrap(v_wrap), .inSync(v_in_sync), .inVisible(v_in_visible)
  );

  assign lineStart  = h_wrap;
  assign frameStart = v_wrap;

  assign decoded = {h_in_sync ? H_SYNC_POL : ~H_SYNC_POL,
                    v_in_sync ? V_SYNC_POL : ~V_SYNC_POL,
                    run && h_in_visible && v_in_visible};
  assign idle    = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

  if (OUT_DELAY == 0) begin : g_no_delay
    assign {hSync, vSync, bright} = decoded;
  end else begin : g_delay
    // Free-running: shifts on every clock so latency is fixed in system clocks.
    logic [2:0] stage [OUT_DELAY];

    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        for (int i = 0; i < OUT_DELAY; i++) stage[i] <= idle;
      end else begin
        stage[0] <= decoded;
        for (int i = 1; i < OUT_DELAY; i++) stage[i] <= stage[i-1];
      end
    end

    assign {hSync, vSync, bright} = stage[OUT_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using two small-geometry instances:
// A (CLK_DIV=4, active-low syncs, no delay) and B (CLK_DIV=1, active-high, delay 2).
module tb_vga_timing_gen;

  localparam int S_HCNT = 0, S_VCNT = 1, S_HS = 2, S_VS = 3, S_BR = 4,
                 S_PT = 5, S_LS = 6, S_FS = 7;
  localparam int DA = 0, DB = 1;

  typedef struct {
    int    cyc;
    int    dut;
    int    sel;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  logic enable;
  int   cyc = 0;
  int   base = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic       a_hs, a_vs, a_br, a_pt, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic       b_hs, b_vs, b_br, b_pt, b_ls, b_fs;
  logic [9:0] b_h, b_v;

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COUNT_W(10), .OUT_DELAY(0)
  ) dut_a (
    .clock(clk), .clear(clear), .enable(enable),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .hCount(a_h), .vCount(a_v),
    .pixelTick(a_pt), .lineStart(a_ls), .frameStart(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COUNT_W(10), .OUT_DELAY(2)
  ) dut_b (
    .clock(clk), .clear(clear), .enable(enable),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .hCount(b_h), .vCount(b_v),
    .pixelTick(b_pt), .lineStart(b_ls), .frameStart(b_fs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(input int d, input int s);
    if (d == DA) begin
      case (s)
        S_HCNT: return int'(a_h);
        S_VCNT: return int'(a_v);
        S_HS:   return int'(a_hs);
        S_VS:   return int'(a_vs);
        S_BR:   return int'(a_br);
        S_PT:   return int'(a_pt);
        S_LS:   return int'(a_ls);
        default: return int'(a_fs);
      endcase
    end
    case (s)
      S_HCNT: return int'(b_h);
      S_VCNT: return int'(b_v);
      S_HS:   return int'(b_hs);
      S_VS:   return int'(b_vs);
      S_BR:   return int'(b_br);
      S_PT:   return int'(b_pt);
      S_LS:   return int'(b_ls);
      default: return int'(b_fs);
    endcase
  endfunction

  // Expectation k cycles after the current base (k=0 is the cycle right after release).
  task automatic ex(input int k, input int d, input int s, input int v, input string nm);
    exp_t e;
    e.cyc = base + k; e.dut = d; e.sel = s; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic goto_k(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every scoreboard entry due this cycle, away from the active edge.
  always @(negedge clk) begin
    int act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_tests++;
        act = sample(sb[i].dut, sb[i].sel);
        if (act != sb[i].val) begin
          n_fail++;
          $display("FAIL %s (cyc %0d): got %0d, expected %0d", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: check at cyc %0d was never sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
    if (clear === 1'b1 && (a_h >= 10'd8 || a_v >= 10'd4)) begin
      n_tests++;
      if (a_br !== 1'b0) begin
        n_fail++;
        $display("FAIL bright_invariant: got bright=%0b at h=%0d v=%0d, expected 0", a_br, a_h, a_v);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: bench did not finish, %0d checks pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear  = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    ex(0, DA, S_HS,   1, "a_rst_hsync");
    ex(0, DA, S_BR,   0, "a_rst_bright");
    ex(0, DA, S_HCNT, 0, "a_rst_hcount");
    ex(0, DA, S_PT,   0, "a_rst_ptick");
    ex(0, DB, S_HS,   0, "b_rst_hsync");
    ex(0, DB, S_VS,   0, "b_rst_vsync");
    ex(0, DB, S_PT,   0, "b_rst_ptick");

    @(posedge clk);
    #1;
    clear = 1'b1;
    base  = cyc;
    // A: pixel n = k/4, h = n%15, v = (n/15)%8, hsync low h 10..12, vsync low v 5..6.
    ex(0,   DA, S_BR,   0,  "a_run_gate");
    ex(1,   DA, S_BR,   1,  "a_first_bright");
    ex(3,   DA, S_PT,   1,  "a_ptick_k3");
    ex(4,   DA, S_HCNT, 1,  "a_h_after_pixel");
    ex(4,   DA, S_PT,   0,  "a_ptick_k4");
    ex(39,  DA, S_HCNT, 9,  "a_h9");
    ex(39,  DA, S_HS,   1,  "a_hs_before_win");
    ex(39,  DA, S_BR,   0,  "a_bright_h9");
    ex(40,  DA, S_HS,   0,  "a_hs_win_start");
    ex(51,  DA, S_HS,   0,  "a_hs_win_last");
    ex(52,  DA, S_HS,   1,  "a_hs_win_end");
    ex(58,  DA, S_LS,   0,  "a_ls_early");
    ex(59,  DA, S_HCNT, 14, "a_h_last");
    ex(59,  DA, S_LS,   1,  "a_ls");
    ex(59,  DA, S_FS,   0,  "a_fs_not_last_line");
    ex(60,  DA, S_HCNT, 0,  "a_h_wrap");
    ex(60,  DA, S_VCNT, 1,  "a_v_inc");
    ex(60,  DA, S_LS,   0,  "a_ls_clear");
    ex(299, DA, S_VS,   1,  "a_vs_before_win");
    ex(300, DA, S_VCNT, 5,  "a_v5");
    ex(300, DA, S_VS,   0,  "a_vs_win_start");
    ex(419, DA, S_VS,   0,  "a_vs_win_last");
    ex(420, DA, S_VCNT, 7,  "a_v7");
    ex(420, DA, S_VS,   1,  "a_vs_win_end");
    ex(479, DA, S_FS,   1,  "a_fs");
    ex(479, DA, S_LS,   1,  "a_ls_at_fs");
    ex(480, DA, S_VCNT, 0,  "a_v_wrap");
    ex(480, DA, S_FS,   0,  "a_fs_clear");
    ex(480, DA, S_BR,   1,  "a_bright_new_frame");
    // B: one pixel per clock, outputs lag counters by 2 clocks, active-high syncs.
    ex(5,   DB, S_PT,   1,  "b_ptick_every_clk");
    ex(9,   DB, S_BR,   1,  "b_bright_before_fall");
    ex(10,  DB, S_HCNT, 10, "b_h10");
    ex(10,  DB, S_BR,   0,  "b_bright_fall_delayed");
    ex(11,  DB, S_HS,   0,  "b_hs_delayed_off");
    ex(12,  DB, S_HS,   1,  "b_hs_delayed_on");
    ex(14,  DB, S_HS,   1,  "b_hs_win_last");
    ex(14,  DB, S_LS,   1,  "b_ls");
    ex(15,  DB, S_HS,   0,  "b_hs_win_end");
    ex(76,  DB, S_VS,   0,  "b_vs_before");
    ex(77,  DB, S_VS,   1,  "b_vs_delayed_on");
    // Enable dropped while prescaler sits at its last count (h=5, v=0).
    ex(503, DA, S_HCNT, 5,  "a_hold_h");
    ex(503, DA, S_PT,   0,  "a_hold_ptick");
    ex(503, DA, S_LS,   0,  "a_hold_ls");
    ex(510, DA, S_HCNT, 5,  "a_hold_h_mid");
    ex(510, DA, S_PT,   0,  "a_hold_ptick_mid");
    ex(510, DA, S_BR,   1,  "a_hold_bright");
    ex(513, DA, S_PT,   1,  "a_resume_ptick");
    ex(513, DA, S_HCNT, 5,  "a_resume_h");
    ex(514, DA, S_HCNT, 6,  "a_resume_inc");
    ex(514, DA, S_PT,   0,  "a_resume_ptick_next");
    // Mid-frame async reset at h=6, v=2.
    ex(634, DA, S_HCNT, 6,  "a_pre_rst_h");
    ex(634, DA, S_VCNT, 2,  "a_pre_rst_v");
    ex(634, DA, S_BR,   1,  "a_pre_rst_bright");
    ex(635, DA, S_HCNT, 0,  "a_midrst_h");
    ex(635, DA, S_VCNT, 0,  "a_midrst_v");
    ex(635, DA, S_BR,   0,  "a_midrst_bright");
    ex(635, DA, S_HS,   1,  "a_midrst_hsync");
    ex(636, DA, S_PT,   0,  "a_midrst_ptick");

    goto_k(503);
    enable = 1'b0;
    goto_k(513);
    enable = 1'b1;
    goto_k(635);
    clear = 1'b0;
    goto_k(637);
    clear = 1'b1;
    base  = cyc;
    ex(0,  DA, S_HCNT, 0,  "a_restart_h");
    ex(0,  DA, S_BR,   0,  "a_restart_bright");
    ex(58, DA, S_LS,   0,  "a_restart_ls_early");
    ex(59, DA, S_LS,   1,  "a_restart_ls");
    ex(59, DA, S_HCNT, 14, "a_restart_h_last");
    ex(59, DA, S_VCNT, 0,  "a_restart_v");

    goto_k(70);
    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: check at cyc %0d left unsampled", sb[i].name, sb[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal and vertical pixel counters, sync pulses with configurable polarity, and a visible-area `bright` signal. Includes an internal pixel-clock-enable divider, so the block runs directly off the 100 MHz system clock.
- Adds line/frame start strobes and an optional output delay pipeline so sync and bright can be aligned with downstream pixel-generation latency.
- Sits between the system clock domain and the VGA DAC / pixel renderer.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1; 4 gives 25 MHz pixels from 100 MHz).
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- H_SYNC_POL, 0, active level of hSync (0 = active-low).
- V_SYNC_POL, 0, active level of vSync.
- COUNT_W, 10, width of hCount/vCount.
- OUT_DELAY, 0, register stages applied to hSync/vSync/bright (0..4).

Ports:
- clock  in  1  system clock.
- clear  in  1  asynchronous, active-low reset.
- enable  in  1  run enable; low freezes all timing state.
- hSync  out  1  horizontal sync.
- vSync  out  1  vertical sync.
- bright  out  1  high while the pixel is in the visible area.
- hCount  out  COUNT_W  current column, 0..H_TOTAL-1.
- vCount  out  COUNT_W  current line, 0..V_TOTAL-1.
- pixelTick  out  1  one-clock pulse on the last system clock of each pixel period.
- lineStart  out  1  one-clock pulse when the next pixel is column 0.
- frameStart  out  1  one-clock pulse when the next pixel is (0,0).

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_ parameters; V_TOTAL = sum of the four V_ parameters.
- Elaboration checks: elaboration fails if 2^COUNT_W < max(H_TOTAL, V_TOTAL), if CLK_DIV < 1, or if OUT_DELAY > 4.
- Reset (clear low, asynchronous):
  - prescaler=0, hCount=0, vCount=0, run=0.
  - pixelTick, lineStart and frameStart = 0.
  - hSync = ~H_SYNC_POL, vSync = ~V_SYNC_POL, bright = 0.
  - All delay stages are loaded with these inactive values.
- Prescaler:
  - When enable=1, counts 0..CLK_DIV-1 and wraps.
  - pixelTick = enable && prescaler==CLK_DIV-1.
  - CLK_DIV=1 gives pixelTick=1 on every enabled clock.
- Counters:
  - On a clock with pixelTick=1: if hCount==H_TOTAL-1 then hCount becomes 0, else hCount increments.
  - On that hCount wrap, vCount increments, and wraps from V_TOTAL-1 to 0.
  - Both counters hold otherwise.
- Strobes (combinational, not delayed):
  - lineStart = pixelTick && hCount==H_TOTAL-1.
  - frameStart = lineStart && vCount==V_TOTAL-1.
- run flag: set on the first enabled clock after reset and never cleared except by reset.
- Decode, from the current counters:
  - hSync is active (H_SYNC_POL) iff H_VISIBLE+H_FRONT <= hCount < H_VISIBLE+H_FRONT+H_SYNC.
  - vSync follows the same rule for the vertical axis with V_SYNC_POL.
  - bright = run && hCount<H_VISIBLE && vCount<V_VISIBLE.
- Output delay:
  - OUT_DELAY=0: hSync, vSync and bright are valid in the same cycle as the counters they decode.
  - OUT_DELAY=N: they lag the counters by exactly N system clocks.
  - The delay stages shift every clock, regardless of enable.
- enable low:
  - Prescaler and counters hold; pixelTick, lineStart and frameStart are 0.
  - Decoded outputs keep reflecting the held counters.
  - When enable rises, counting resumes from the held prescaler value.
- Reset mid-frame: all state returns to its reset value immediately. Counting restarts at (0,0) with prescaler 0 after clear rises.
- Invariant: bright is never 1 while hCount>=H_VISIBLE or vCount>=V_VISIBLE (with OUT_DELAY=0).

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - the H_TOTAL/V_TOTAL derivation;
  - sync-window bound constants.
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - inputs: step, parameter TOTAL, parameters SYNC_START/SYNC_END;
  - outputs: count, wrap, inSync, inVisible.

Test Plan:
- Defaults, clear low for 20 ns then high -> pixelTick every 4th clock. hCount reaches 799 then wraps to 0 after 3200 clocks. lineStart pulses exactly once per 3200 clocks; frameStart once per 1,680,000 clocks.
- Defaults -> hSync=0 exactly for hCount 656..751 and vSync=0 exactly for vCount 490..491. bright=1 only for hCount<640 and vCount<480, and bright=0 everywhere else.
- H_SYNC_POL=1, V_SYNC_POL=1, CLK_DIV=1 -> hSync=1 only at hCount 656..751, with a new pixel on every clock. During reset hSync=0 and vSync=0.
- OUT_DELAY=2 -> hSync falls exactly 2 clocks after hCount becomes 656. bright falls 2 clocks after hCount becomes 640.
- enable dropped for 50 clocks at hCount=100 -> hCount stays at 100 and strobes stay 0 throughout. On resume, the next increment occurs after the remaining prescaler count.
- clear pulsed low at vCount=300, hCount=400 -> counters read 0 within the same cycle and bright=0. After release, the first lineStart occurs 3200 clocks later.
